// File: rtl/uart_rx_deserializer.sv
// ============================================================================
// uart_rx_deserializer
// ----------------------------------------------------------------------------
// Receive side of the UART link. Recovers parallel characters from the serial
// line driven by the peer's tx. The line is synchronized, sampled at mid-bit
// with a clocks-per-bit counter, and start/data/stop bits are checked. Good
// characters go into a single-entry valid/ready holding register that feeds
// the receive-side consumer.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : one parity bit follows the data bits and is checked against
//               PARITY_ODD. A mismatch pulses parity_err and drops the char.
//   undefined : frame is start + data + stop, parity_err is constant 0.
//
// Parameters:
//   CLKS_PER_BIT  pclk cycles per serial bit (even, >= 4)
//   DATA_WIDTH    data bits per frame (5..8), sent LSB first
//   PARITY_ODD    0 = even parity, 1 = odd parity (parity feature only)
//
// Ports:
//   pclk         in   system clock
//   areset       in   synchronous active-high reset
//   rx           in   serial line, idles high
//   rx_data      out  received character, stable while rx_valid=1
//   rx_valid     out  character available
//   rx_ready     in   consumer accepts the character
//   frame_err    out  one-cycle pulse, stop bit sampled 0
//   overrun_err  out  one-cycle pulse, good character dropped (register full)
//   parity_err   out  one-cycle pulse, parity mismatch
//   busy         out  high whenever the receiver FSM is not idle
// ============================================================================
module uart_rx_deserializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_WIDTH   = 8,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic                  pclk,
   input  logic                  areset,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  frame_err,
   output logic                  overrun_err,
   output logic                  parity_err,
   output logic                  busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_WIDTH);

   // The start sample happens CLKS_PER_BIT/2-1 cycles after START is entered,
   // counting the entry cycle itself, so the compare value is one lower.
   localparam logic [CW-1:0] HALF_SAMPLE = CW'(CLKS_PER_BIT / 2 - 2);
   localparam logic [CW-1:0] FULL_SAMPLE = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   state_t                state;
   logic                  sync1;
   logic                  rxs;
   logic [DATA_WIDTH-1:0] shreg;
   logic [BW-1:0]         bit_idx;
   logic [CW-1:0]         cnt;
`ifdef UART_RX_PARITY_EN
   logic                  par_flag;
`endif

   // Two-flop synchronizer on the asynchronous serial line. Both flops reset
   // to the idle level so a reset never looks like a start bit.
   always_ff @(posedge pclk) begin
      if (areset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx;
         rxs   <= sync1;
      end
   end

   // Receiver FSM plus the holding register. Error pulses default low every
   // cycle; the holding register clears after a transfer unless the STOP
   // state reloads it in the same cycle.
   always_ff @(posedge pclk) begin
      if (areset) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_idx     <= '0;
         cnt         <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err  <= 1'b0;
         par_flag    <= 1'b0;
`endif
      end else begin
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err  <= 1'b0;
`endif
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end

            START: begin
               if (cnt == HALF_SAMPLE) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  if (rxs) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= DATA;
`ifdef UART_RX_PARITY_EN
                     par_flag <= 1'b0;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (cnt == FULL_SAMPLE) begin
                  cnt   <= '0;
                  shreg <= {rxs, shreg[DATA_WIDTH-1:1]};
                  if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            // Flag is set when data plus parity bit does not have the
            // selected (even/odd) number of ones.
            PARITY: begin
               if (cnt == FULL_SAMPLE) begin
                  cnt      <= '0;
                  par_flag <= rxs ^ (^shreg) ^ PARITY_ODD;
                  state    <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif

            STOP: begin
               if (cnt == FULL_SAMPLE) begin
                  cnt <= '0;
                  if (!rxs) begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     if (par_flag) begin
                        parity_err <= 1'b1;
                     end else
`endif
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun_err <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // Line held low past the stop bit: wait for it to return high so
            // a long break is not mistaken for a stream of start bits.
            BREAK: begin
               if (rxs) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   // No parity bit in the frame, so a parity error can never occur; the
   // parameter is folded in only to keep it referenced.
   assign parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ============================================================================
// tb_uart_rx_deserializer
// ----------------------------------------------------------------------------
// Directed testbench for uart_rx_deserializer (default parameters). Stimulus
// pushes the expected receiver events into a scoreboard queue; an independent
// monitor pops and compares whenever the DUT shows a transfer or error pulse.
// Event cycle numbers are the pclk edge count at which the DUT registers the
// event (T0 = first edge seeing rx low, stop sample at T0+153).
// ============================================================================
module tb_uart_rx_deserializer;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int STOP_OFS = 169;
`else
   localparam int STOP_OFS = 153;
`endif

   logic       pclk = 1'b0;
   logic       areset;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun_err;
   logic       parity_err;
   logic       busy;

   uart_rx_deserializer #(
      .CLKS_PER_BIT(CPB),
      .DATA_WIDTH(8),
      .PARITY_ODD(1'b0)
   ) dut (
      .pclk(pclk),
      .areset(areset),
      .rx(rx),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .frame_err(frame_err),
      .overrun_err(overrun_err),
      .parity_err(parity_err),
      .busy(busy)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef enum int {EV_DATA, EV_FRAME, EV_PARITY, EV_OVERRUN} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   ev_t  sb[$];
   int   checks = 0;
   int   fails  = 0;
   int   busy_fall = -1;
   logic busy_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
   logic force_bad_par = 1'b0;
`endif

   // Expected event; cycle -1 means the arrival cycle is not checked.
   task automatic pushEv(input ev_kind_t kind, input logic [7:0] data, input int at);
      ev_t e;
      e.kind = kind;
      e.data = data;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic scoreEvent(input ev_kind_t kind, input logic [7:0] data);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         fails++;
         $display("[TB] FAIL sb_unexpected: got kind=%0d data=%h at cyc=%0d, expected no event",
                  kind, data, cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || (kind == EV_DATA && e.data !== data) ||
             (e.cyc >= 0 && e.cyc != cyc)) begin
            fails++;
            $display("[TB] FAIL sb_event: got kind=%0d data=%h cyc=%0d, expected kind=%0d data=%h cyc=%0d",
                     kind, data, cyc, e.kind, e.data, e.cyc);
         end
      end
   endtask

   // Monitor: samples 1 time unit after the falling edge, well clear of the
   // active edge and after any input change the stimulus made on that edge.
   always @(negedge pclk) begin
      #1;
      if (areset === 1'b0) begin
         if (frame_err === 1'b1)   scoreEvent(EV_FRAME, 8'h00);
         if (parity_err === 1'b1)  scoreEvent(EV_PARITY, 8'h00);
         if (overrun_err === 1'b1) scoreEvent(EV_OVERRUN, 8'h00);
         if (rx_valid === 1'b1 && rx_ready === 1'b1) scoreEvent(EV_DATA, rx_data);
         if (busy_prev === 1'b1 && busy === 1'b0) busy_fall = cyc;
      end
      busy_prev = busy;
   end

   task automatic driveBit(input logic b);
      rx = b;
      repeat (CPB) @(negedge pclk);
   endtask

   // Sends one frame starting at the current falling edge, LSB first.
   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
      driveBit((^data) ^ force_bad_par);
`endif
      driveBit(stop_bit);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_rx_data"}, rx_data, 0);
      checkOutput({tag, "_rx_valid"}, rx_valid, 0);
      checkOutput({tag, "_frame_err"}, frame_err, 0);
      checkOutput({tag, "_overrun_err"}, overrun_err, 0);
      checkOutput({tag, "_parity_err"}, parity_err, 0);
      checkOutput({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t0;
      rx       = 1'b1;
      rx_ready = 1'b1;
      areset   = 1'b1;
      repeat (3) @(negedge pclk);
      checkAllZero("reset");
      areset = 1'b0;
      repeat (5) @(negedge pclk);

      // 0xA5 8N1, consumer ready
      t0 = cyc + 1;
      pushEv(EV_DATA, 8'hA5, t0 + STOP_OFS);
      applyStimulus(8'hA5, 1'b1);
      repeat (4) @(negedge pclk);
      checkOutput("a5_busy_fall", busy_fall, t0 + STOP_OFS);
      checkOutput("a5_valid_clear", rx_valid, 0);

      // Glitch of 4 cycles: false start
      t0 = cyc + 1;
      rx = 1'b0;
      repeat (4) @(negedge pclk);
      rx = 1'b1;
      repeat (20) @(negedge pclk);
      checkOutput("false_start_busy_fall", busy_fall, t0 + 9);
      checkOutput("false_start_valid", rx_valid, 0);

      // 0x3C with stop bit 0, line held low, then 0x11
      t0 = cyc + 1;
      pushEv(EV_FRAME, 8'h00, t0 + STOP_OFS);
      applyStimulus(8'h3C, 1'b0);
      repeat (40) @(negedge pclk);
      checkOutput("break_busy", busy, 1);
      rx = 1'b1;
      repeat (4) @(negedge pclk);
      checkOutput("break_exit_busy", busy, 0);
      t0 = cyc + 1;
      pushEv(EV_DATA, 8'h11, t0 + STOP_OFS);
      applyStimulus(8'h11, 1'b1);
      repeat (4) @(negedge pclk);

      // Back-to-back 0x01, 0x02 with consumer stalled -> overrun
      rx_ready = 1'b0;
      repeat (2) @(negedge pclk);
      applyStimulus(8'h01, 1'b1);
      t0 = cyc + 1;
      pushEv(EV_OVERRUN, 8'h00, t0 + STOP_OFS);
      applyStimulus(8'h02, 1'b1);
      repeat (3) @(negedge pclk);
      checkOutput("overrun_valid_held", rx_valid, 1);
      checkOutput("overrun_data_held", rx_data, 8'h01);
      pushEv(EV_DATA, 8'h01, cyc);
      rx_ready = 1'b1;
      @(negedge pclk);
      rx_ready = 1'b0;
      checkOutput("overrun_valid_after_xfer", rx_valid, 0);
      rx_ready = 1'b1;
      repeat (4) @(negedge pclk);

`ifdef UART_RX_PARITY_EN
      // 0x07 with wrong (0) then correct (1) even parity bit
      force_bad_par = 1'b1;
      t0 = cyc + 1;
      pushEv(EV_PARITY, 8'h00, t0 + STOP_OFS);
      applyStimulus(8'h07, 1'b1);
      force_bad_par = 1'b0;
      t0 = cyc + 1;
      pushEv(EV_DATA, 8'h07, t0 + STOP_OFS);
      applyStimulus(8'h07, 1'b1);
      repeat (4) @(negedge pclk);
      // keep the trailing bits of the 0xFF frame high after reset
      force_bad_par = 1'b1;
`endif

      // Reset mid-DATA of 0xFF, then 0x5A
      fork
         applyStimulus(8'hFF, 1'b1);
         begin
            repeat (60) @(negedge pclk);
            checkOutput("pre_reset_busy", busy, 1);
            areset = 1'b1;
            @(negedge pclk);
            areset = 1'b0;
            checkAllZero("midframe_reset");
         end
      join
`ifdef UART_RX_PARITY_EN
      force_bad_par = 1'b0;
`endif
      repeat (4) @(negedge pclk);
      t0 = cyc + 1;
      pushEv(EV_DATA, 8'h5A, t0 + STOP_OFS);
      applyStimulus(8'h5A, 1'b1);
      repeat (20) @(negedge pclk);

      checkOutput("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
